inst_rom_loader: RTL and testbench

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

---
 rtl/inst_rom_loader.sv | 205 ++++++++++++++++++++
 tb/tb_inst_rom_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// ---------------------------------------------------------------------------
// inst_rom_loader
//
// Instruction memory that a byte-serial loader fills in before the core runs.
// The loader sends a big-endian 16-bit word count N and then N 32-bit words,
// each most significant byte first. Until the whole image has arrived the
// core is held in reset and its fetch port reads as zero. Once the last word
// is stored, the core is released and fetches read the memory
// combinationally.
//
// Parameters
//   DEPTH_LOG2   log2 of memory depth in 32-bit words
//
// Ports
//   clk          sole clock; all state changes on the rising edge
//   rst          synchronous, active-high reset (memory contents are kept)
//   rom_ce_i     fetch enable from the core
//   rom_addr_i   fetch byte address; bits [1:0] and the bits above the
//                index field are ignored, so the index wraps modulo depth
//   rom_data_o   fetched instruction word, or 0 when disabled or held
//   ld_valid     loader byte valid
//   ld_data      loader byte
//   ld_ready     byte accepted when ld_valid and ld_ready are high at an edge
//   reload       one-cycle request to restart the load sequence
//   cpu_rst_o    registered reset to the core; high until the image is loaded
//   load_done    image completely loaded (inverse of cpu_rst_o)
//   ovf_err      sticky flag: the image held more words than the memory
// ---------------------------------------------------------------------------
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic        reload,
    output logic        cpu_rst_o,
    output logic        load_done,
    output logic        ovf_err
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

    // Load sequencer states.
    localparam logic [1:0] ST_LEN_HI = 2'd0;
    localparam logic [1:0] ST_LEN_LO = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_q,   state_d;
    logic [15:0] count_q,   count_d;    // image length N in words
    logic [15:0] widx_q,    widx_d;     // index of the word being assembled
    logic [1:0]  bcnt_q,    bcnt_d;     // byte position inside current word
    logic [31:0] asm_q,     asm_d;      // word assembly shift register
    logic        ovf_q,     ovf_d;
    logic        cpu_rst_q, cpu_rst_d;

    logic [31:0] mem [DEPTH];

    // Memory write port, driven from the sequencer.
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    logic accept;
    logic idx_in_range;
    logic last_word;

    // Fetch address bits that play no part in indexing the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr_i[1:0], rom_addr_i[31:DEPTH_LOG2+2]};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // reload and rst both refuse the byte offered in the same cycle, so a
    // byte is never half-consumed across a restart.
    assign ld_ready = (state_q != ST_DONE) && !rst && !reload;
    assign accept   = ld_valid && ld_ready;

    // Word index is compared at full width so images longer than the memory
    // are detected instead of silently wrapping onto earlier words.
    assign idx_in_range = (32'(widx_q) < DEPTH);
    // Extended by one bit so that widx_q + 1 never wraps before comparing.
    assign last_word    = ((17'(widx_q) + 17'd1) == 17'(count_q));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        widx_d    = widx_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = DEPTH_LOG2'(widx_q);
        // The fourth byte is written together with the three already held,
        // so the word lands in memory on the same edge it completes.
        mem_wdata = {asm_q[23:0], ld_data};

        if (reload) begin
            state_d = ST_LEN_HI;
            count_d = 16'd0;
            widx_d  = 16'd0;
            bcnt_d  = 2'd0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            case (state_q)
                ST_LEN_HI: begin
                    count_d[15:8] = ld_data;
                    state_d       = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    count_d = {count_q[15:8], ld_data};
                    if ({count_q[15:8], ld_data} == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        widx_d  = 16'd0;
                        bcnt_d  = 2'd0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    asm_d  = {asm_q[23:0], ld_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Words beyond the memory are still consumed from the
                        // stream; they only raise the sticky error flag.
                        if (idx_in_range) begin
                            mem_we = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        widx_d = widx_q + 16'd1;
                        if (last_word) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Registered core reset: drops on the edge that enters DONE.
        cpu_rst_d = (state_d != ST_DONE);
    end

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LEN_HI;
            count_q   <= 16'd0;
            widx_q    <= 16'd0;
            bcnt_q    <= 2'd0;
            asm_q     <= 32'd0;
            ovf_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            widx_q    <= widx_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            ovf_q     <= ovf_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction memory
    // ------------------------------------------------------------------
    // Deliberately not reset: neither rst nor reload touches the image. The
    // write enable already excludes the reset cycle through ld_ready.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Combinational fetch; the core sees zeros while it is held in reset.
    always_comb begin
        rom_data_o = 32'd0;
        if (rom_ce_i && !cpu_rst_q && !rst) begin
            rom_data_o = mem[rom_addr_i[DEPTH_LOG2+1:2]];
        end
    end

    assign cpu_rst_o = cpu_rst_q;
    assign load_done = ~cpu_rst_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

    localparam int DLA  = 10;
    localparam int DLB  = 2;
    localparam int DEPA = 1 << DLA;
    localparam int DEPB = 1 << DLB;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        reload;

    logic [31:0] rom_data_a, rom_data_b;
    logic        ld_ready_a, ld_ready_b;
    logic        cpu_rst_a, cpu_rst_b;
    logic        load_done_a, load_done_b;
    logic        ovf_a, ovf_b;

    always #5 clk = ~clk;

    // Two instances fed the same stream: default depth, and a 4-word memory
    // that overflows on longer images.
    inst_rom_loader #(.DEPTH_LOG2(DLA)) dut_a (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
        .rom_data_o(rom_data_a), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready_a), .reload(reload), .cpu_rst_o(cpu_rst_a),
        .load_done(load_done_a), .ovf_err(ovf_a)
    );

    inst_rom_loader #(.DEPTH_LOG2(DLB)) dut_b (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
        .rom_data_o(rom_data_b), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready_b), .reload(reload), .cpu_rst_o(cpu_rst_b),
        .load_done(load_done_b), .ovf_err(ovf_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: counts bytes received since the last restart and
    // derives everything from that count and the stream contents.
    // ------------------------------------------------------------------
    int          m_k = 0;      // bytes accepted since restart
    int          m_n = 0;      // word count from header
    logic [31:0] m_sh = 0;
    bit          m_ovf_a = 0, m_ovf_b = 0;
    logic [31:0] ma [DEPA];
    bit          wa [DEPA];
    logic [31:0] mb [DEPB];
    bit          wb [DEPB];

    function automatic bit m_done();
        return (m_k >= 2) && (m_k == 2 + 4 * m_n);
    endfunction

    task automatic model_edge(input bit v, input logic [7:0] d, input bit rl, input bit r);
        int w;
        if (r || rl) begin
            m_k = 0; m_n = 0; m_ovf_a = 0; m_ovf_b = 0;
        end else if (v && !m_done()) begin
            if (m_k == 0) m_n = int'(d) * 256;
            else if (m_k == 1) m_n = m_n + int'(d);
            else begin
                m_sh = {m_sh[23:0], d};
                if ((m_k - 2) % 4 == 3) begin
                    w = (m_k - 2) / 4;
                    if (w < DEPA) begin ma[w] = m_sh; wa[w] = 1; end else m_ovf_a = 1;
                    if (w < DEPB) begin mb[w] = m_sh; wb[w] = 1; end else m_ovf_b = 1;
                end
            end
            m_k++;
        end
    endtask

    // One clock cycle of loader stimulus with checks before and after the edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit rl, input bit r);
        bit exp_rdy;
        ld_valid = v; ld_data = d; reload = rl; rst = r;
        if (r) rom_ce_i = 1'b1;
        #1;
        exp_rdy = !r && !rl && !m_done();
        chk("ld_ready_a", 32'(ld_ready_a), 32'(exp_rdy));
        chk("ld_ready_b", 32'(ld_ready_b), 32'(exp_rdy));
        if (r) begin
            chk("rst_fetch_a", rom_data_a, 32'd0);
            chk("rst_fetch_b", rom_data_b, 32'd0);
        end
        @(posedge clk);
        model_edge(v, d, rl, r);
        #1;
        chk("cpu_rst_a", 32'(cpu_rst_a), 32'(!m_done()));
        chk("cpu_rst_b", 32'(cpu_rst_b), 32'(!m_done()));
        chk("load_done_a", 32'(load_done_a), 32'(m_done()));
        chk("ovf_a", 32'(ovf_a), 32'(m_ovf_a));
        chk("ovf_b", 32'(ovf_b), 32'(m_ovf_b));
    endtask

    // One idle cycle with a fetch checked against the model.
    task automatic fetch(input bit ce, input logic [31:0] addr);
        int ia, ib;
        ld_valid = 1'b0; reload = 1'b0;
        rom_ce_i = ce; rom_addr_i = addr;
        ia = int'(addr[DLA+1:2]);
        ib = int'(addr[DLB+1:2]);
        #1;
        if (ce && m_done() && !rst) begin
            if (wa[ia]) chk("fetch_a", rom_data_a, ma[ia]);
            if (wb[ib]) chk("fetch_b", rom_data_b, mb[ib]);
        end else begin
            chk("fetch_off_a", rom_data_a, 32'd0);
            chk("fetch_off_b", rom_data_b, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Send a byte stream, restarting from the first byte whenever a
    // disturbance (reload or rst) is injected. Bounded by a cycle budget.
    task automatic send(input logic [7:0] q[$], input int gap_at, input int gap_len,
                        input int p_idle, input int p_dist);
        int  p = 0, budget = 0, gaps = 0;
        bit  v, rl, r, acc;
        while (p < q.size() && budget < 3000) begin
            v = 1'b1; rl = 1'b0; r = 1'b0;
            if (p_idle > 0 && $urandom_range(99) < p_idle) v = 1'b0;
            if (p == gap_at && gaps < gap_len) begin v = 1'b0; gaps++; end
            if (p_dist > 0 && $urandom_range(999) < p_dist) begin
                if ($urandom_range(1) == 0) rl = 1'b1; else r = 1'b1;
            end
            acc = v && !r && !rl && !m_done();
            cyc(v, q[p], rl, r);
            if (r || rl) p = 0;
            else if (acc) p++;
            budget++;
        end
        n_vec++;
        if (p < q.size()) begin
            n_bad++;
            $display("FAIL stream_budget: sent %0d bytes, needed %0d", p, q.size());
        end
        rst = 1'b0;
    endtask

    function automatic void add_word(ref logic [7:0] q[$], input logic [31:0] w);
        q.push_back(w[31:24]); q.push_back(w[23:16]);
        q.push_back(w[15:8]);  q.push_back(w[7:0]);
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       exp_rst;
    } ld_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } fetch_vec_t;

    initial begin
        ld_vec_t     tv [10];
        fetch_vec_t  fv [4];
        logic [7:0]  b034 [10];
        logic [7:0]  q[$];
        int          nw;

        b034 = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h0A, 8'h34, 8'h02, 8'h00, 8'h14};
        for (int i = 0; i < 10; i++) begin
            tv[i].d = b034[i];
            tv[i].exp_rst = (i < 9) ? 1'b1 : 1'b0;
        end
        fv[0] = '{32'h0000_0000, 32'h3401000A, 32'h3401000A};
        fv[1] = '{32'h0000_0004, 32'h34020014, 32'h34020014};
        fv[2] = '{32'h0000_0006, 32'h34020014, 32'h34020014};
        fv[3] = '{32'hFFF0_0007, 32'h34020014, 32'h34020014};

        rom_ce_i = 1'b1; rom_addr_i = 32'd0; ld_valid = 1'b0; ld_data = 8'd0;
        reload = 1'b0; rst = 1'b1;

        // Reset state.
        cyc(1'b1, 8'hAA, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("reset_cpu_rst", 32'(cpu_rst_a), 32'd1);
        rst = 1'b0;

        // Basic two-word load, table driven.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, tv[i].d, 1'b0, 1'b0);
            chk("tbl_cpu_rst", 32'(cpu_rst_a), 32'(tv[i].exp_rst));
        end
        cyc(1'b1, 8'h55, 1'b0, 1'b0);   // DONE refuses further bytes
        for (int i = 0; i < 4; i++) begin
            fetch(1'b1, fv[i].addr);
            chk("tbl_fetch_a", rom_data_a, fv[i].exp_a);
            chk("tbl_fetch_b", rom_data_b, fv[i].exp_b);
        end

        // Same load with a 3-cycle valid gap between bytes 5 and 6.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        q = {};
        for (int i = 0; i < 10; i++) q.push_back(b034[i]);
        send(q, 5, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            fetch(1'b1, fv[i].addr);
            chk("gap_fetch_a", rom_data_a, fv[i].exp_a);
        end

        // Empty image.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        q = {8'h00, 8'h00};
        send(q, -1, 0, 0, 0);
        chk("n0_done", 32'(load_done_a), 32'd1);
        chk("n0_ovf", 32'(ovf_a), 32'd0);
        cyc(1'b1, 8'h12, 1'b0, 1'b0);

        // Five words into the 4-word instance: overflow, W0 kept.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        q = {8'h00, 8'h05};
        for (int i = 0; i < 5; i++) add_word(q, 32'h1111_1111 * (i + 1));
        send(q, -1, 0, 0, 0);
        chk("ovf_b_set", 32'(ovf_b), 32'd1);
        chk("ovf_a_clear", 32'(ovf_a), 32'd0);
        chk("ovf_done", 32'(load_done_b), 32'd1);
        fetch(1'b1, 32'h0);
        chk("ovf_w0_b", rom_data_b, 32'h1111_1111);
        fetch(1'b1, 32'h10);
        chk("ovf_w4_a", rom_data_a, 32'h5555_5555);

        // Reload in DONE, single-word image; old word 1 survives.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("reload_cpu_rst", 32'(cpu_rst_a), 32'd1);
        chk("reload_ovf_clr", 32'(ovf_b), 32'd0);
        q = {8'h00, 8'h01};
        add_word(q, 32'hDEAD_BEEF);
        send(q, -1, 0, 0, 0);
        fetch(1'b1, 32'h0);
        chk("reload_w0", rom_data_a, 32'hDEAD_BEEF);
        fetch(1'b1, 32'h4);
        chk("reload_w1_a", rom_data_a, 32'h2222_2222);
        chk("reload_w1_b", rom_data_b, 32'h2222_2222);

        // rst two bytes into a data word, then a full restart.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        q = {8'h00, 8'h02, 8'hAB, 8'hCD};
        send(q, -1, 0, 0, 0);
        fetch(1'b1, 32'h0);
        cyc(1'b1, 8'hEF, 1'b0, 1'b1);
        q = {8'h00, 8'h02};
        add_word(q, 32'hCAFE_F00D);
        add_word(q, 32'h0BAD_C0DE);
        send(q, -1, 0, 0, 0);
        fetch(1'b1, 32'h0);
        chk("rst_restart_w0", rom_data_a, 32'hCAFE_F00D);
        fetch(1'b1, 32'h4);
        chk("rst_restart_w1", rom_data_b, 32'h0BAD_C0DE);
        fetch(1'b0, 32'h0);
        chk("ce_off", rom_data_a, 32'd0);

        // Randomized loads with idle cycles, reloads and resets.
        for (int it = 0; it < 30; it++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            nw = $urandom_range(7);
            q = {8'h00, 8'(nw)};
            for (int i = 0; i < nw; i++) add_word(q, $urandom);
            send(q, -1, 0, 30, 15);
            for (int i = 0; i < 6; i++)
                fetch($urandom_range(3) != 0, $urandom);
            for (int i = 0; i < DEPB; i++)
                fetch(1'b1, {$urandom_range(255), 24'h0} | 32'(i * 4 + $urandom_range(3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
